wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Writeback-port arbiter in front of the integer register file's single write port. It merges two writeback sources:
- the in-order pipeline WB stage, which has priority and no backpressure;
- a long-latency unit (mul/div), whose results it buffers in a small FIFO.

It drives the register file's rd_wen/rd_addr/rd_data, reports which registers have results still queued so decode can stall dependents, and requests a pipeline stall when queued results have been starved too long.

## Interface
- XLEN, `XLEN — register width, 32 or 64.
- DEPTH, 4 — long-latency result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4 — consecutive blocked cycles before pipe_stall is requested; ≥1.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- pipe_wen  input  1  pipeline WB write request.
- pipe_rd  input  5  pipeline WB destination.
- pipe_data  input  XLEN  pipeline WB data.
- lu_valid  input  1  long-latency result valid.
- lu_ready  output  1  FIFO can accept; equals !full.
- lu_rd  input  5  long-latency destination.
- lu_data  input  XLEN  long-latency data.
- query_rs1  input  5  decode source 1.
- query_rs2  input  5  decode source 2.
- rs1_pending  output  1  query_rs1 matches a queued entry.
- rs2_pending  output  1  query_rs2 matches a queued entry.
- pipe_stall  output  1  registered; asks the pipeline to hold WB.
- rd_wen  output  1  register-file write enable.
- rd_addr  output  5  register-file write address.
- rd_data  output  XLEN  register-file write data.

## Operation
- Enqueue: lu_valid && lu_ready writes {lu_rd, lu_data} at the tail on the clock edge.
  - lu_rd==0 is accepted (handshake completes) and dropped; no entry is allocated.
- Write-port grant is combinational each cycle:
  - **pipe_stall==0:**
    - pipe_wen && pipe_rd!=0: the pipeline write wins.
    - otherwise, if the FIFO is non-empty, the FIFO head wins and is dequeued at the edge.
  - **pipe_stall==1:** the FIFO head wins. pipe_wen is ignored, and upstream holds its instruction.
  - A pipeline write to x0 never occupies the port: rd_wen=0 for it, and the head may drain that cycle.
- rd_wen=0 when nothing is granted. rd_addr and rd_data are then don't-care but are driven to 0.
- Pending: rsN_pending=1 iff query_rsN!=0 and it equals rd of any valid entry, including the head being written this cycle.
  - The register file's internal forwarding covers the granted write.
- Starvation counter: width $clog2(STARVE_LIMIT+1).
  - Increments on each cycle the FIFO is non-empty and the head is not granted.
  - Clears on a head dequeue or when the FIFO is empty.
  - A blocked cycle with counter==STARVE_LIMIT-1 sets pipe_stall at the next edge.
  - pipe_stall clears at the edge after the next head dequeue.
- FIFO pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare, and pointers wrap modulo 2·DEPTH.
- A full FIFO with a simultaneous dequeue still shows lu_ready=0 that cycle. Ready rises the cycle after the dequeue.

## Timing
- Reset (async assert, sync to next edge on deassert): FIFO empty, counter 0, pipe_stall 0, lu_ready 1, rd_wen 0, rsN_pending 0.
  - While reset_n is low, rd_wen is forced 0 regardless of pipe_wen.
- Reset mid-operation discards all queued entries; no writes issue.
- Pipeline write latency is 0: same-cycle passthrough to rd_*.
- FIFO latency: minimum 1 cycle. An entry enqueued at edge N is granted no earlier than cycle N+1; there is no empty bypass.
- Worst-case FIFO head wait with continuous pipe_wen: STARVE_LIMIT+1 cycles after it becomes head.
- The FIFO keeps order; entries are written in acceptance order. Two entries to the same rd are both written, in order.

## Test plan
- **Reset:** assert reset_n=0 mid-stream with 3 entries queued and pipe_wen=1 -> rd_wen=0, lu_ready=1, pipe_stall=0; no queued write appears after release.
- **Idle drain:** lu writes x5=0x11 at edge 0 with pipe_wen=0 -> cycle 1 rd_wen=1, rd_addr=5, rd_data=0x11; cycle 2 rd_wen=0.
- **Starvation, STARVE_LIMIT=4:** enqueue x7=0xA5 at edge 0, continuous pipe_wen to x3.
  - Cycles 1–4: pipeline writes x3.
  - Cycle 5: pipe_stall=1, rd_addr=7, rd_data=0xA5.
  - Cycle 6: pipe_stall=0.
- **Full:** DEPTH=4, 4 enqueues to x8–x11 with pipe_wen=1 -> lu_ready=0 after the 4th; a 5th lu_valid is held.
  - Entries drain in order 8,9,10,11 when pipe_wen drops.
- **x0 handling:** lu_rd=0 -> accepted, never written, rsN_pending stays 0.
  - pipe_wen with pipe_rd=0 plus a queued x9 -> x9 is written that same cycle.
- **Pending:** queue x12 -> query_rs1=12 gives rs1_pending=1, query_rs2=0 gives 0.
  - rs1_pending stays 1 through the cycle x12 is written, then 0 on the next cycle.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges the in-order pipeline WB stage and a buffered
// long-latency unit onto the register file's single write port.
// The pipeline has priority, and a starvation counter can request a pipeline stall.
// The block also reports which registers still have results waiting in the queue.
module wb_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pipe_wen,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic [4:0]      query_rs1,
    input  logic [4:0]      query_rs2,
    output logic            rs1_pending,
    output logic            rs2_pending,
    output logic            pipe_stall,
    output logic            rd_wen,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_TRIP = CW'(STARVE_LIMIT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             stall_q, stall_d;
    logic             out_en_q;

    logic [AW-1:0]    wr_idx, rd_idx;
    logic             empty, full;
    logic             pipe_hit, pipe_gnt, head_gnt, push;
    wb_entry_t        head;

    // Pointer-derived FIFO status; the extra MSB separates full from empty.
    always_comb begin
        wr_idx = wr_ptr_q[AW-1:0];
        rd_idx = rd_ptr_q[AW-1:0];
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
        head   = mem_q[rd_idx];
    end

    // Write-port grant: the pipeline wins unless a stall is in force or it targets x0.
    always_comb begin
        pipe_hit = pipe_wen && (pipe_rd != 5'd0);
        pipe_gnt = !stall_q && pipe_hit;
        head_gnt = !empty && (stall_q || !pipe_hit);
        push     = lu_valid && !full && (lu_rd != 5'd0);
    end

    // Register-file port drive; held off until the first edge after reset release.
    always_comb begin
        rd_wen  = 1'b0;
        rd_addr = 5'd0;
        rd_data = '0;
        if (out_en_q) begin
            if (pipe_gnt) begin
                rd_wen  = 1'b1;
                rd_addr = pipe_rd;
                rd_data = pipe_data;
            end else if (head_gnt) begin
                rd_wen  = 1'b1;
                rd_addr = head.rd;
                rd_data = head.data;
            end
        end
    end

    // Next-state for pointers, entry valid bits and the starvation tracking.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        stall_d  = stall_q;
        if (head_gnt) begin
            rd_ptr_d        = rd_ptr_q + PW'(1);
            valid_d[rd_idx] = 1'b0;
        end
        if (push) begin
            wr_ptr_d        = wr_ptr_q + PW'(1);
            valid_d[wr_idx] = 1'b1;
        end
        if (empty || head_gnt) begin
            cnt_d = '0;
            if (head_gnt) begin
                stall_d = 1'b0;
            end
        end else begin
            if (cnt_q == CNT_TRIP) begin
                stall_d = 1'b1;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            cnt_q    <= '0;
            stall_q  <= 1'b0;
            out_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            out_en_q <= 1'b1;
        end
    end

    // Entry storage; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx].rd   <= lu_rd;
            mem_q[wr_idx].data <= lu_data;
        end
    end

    // Hazard lookup across every queued entry, including the head being written.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[AW'(i)] && (mem_q[AW'(i)].rd == query_rs1) && (query_rs1 != 5'd0)) begin
                rs1_pending = 1'b1;
            end
            if (valid_q[AW'(i)] && (mem_q[AW'(i)].rd == query_rs2) && (query_rs2 != 5'd0)) begin
                rs2_pending = 1'b1;
            end
        end
    end

    assign lu_ready   = !full;
    assign pipe_stall = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus random traffic checked against
// a queue-based behavioural model of the writeback arbiter.
module tb_wb_port_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            pipe_wen;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            lu_valid;
    logic            lu_ready;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data;
    logic [4:0]      query_rs1, query_rs2;
    logic            rs1_pending, rs2_pending;
    logic            pipe_stall;
    logic            rd_wen;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .pipe_stall(pipe_stall),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_wait  = 0;
    bit   m_stall = 1'b0;
    bit   m_live  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic        obs_wen, obs_ready, obs_stall, obs_p1, obs_p2;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic cycle(input bit rst, input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] q1, input logic [4:0] q2);
        bit          hit, pgo, hgo, e_ready, e_wen, e_p1, e_p2;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        int          n;
        ent_t        e;
        @(negedge clk);
        reset_n   = rst;
        pipe_wen  = pw;
        pipe_rd   = prd;
        pipe_data = pd;
        lu_valid  = lv;
        lu_rd     = lrd;
        lu_data   = ld;
        query_rs1 = q1;
        query_rs2 = q2;
        if (!rst) begin
            mq.delete();
            m_wait  = 0;
            m_stall = 1'b0;
            m_live  = 1'b0;
        end
        #1;
        n       = mq.size();
        hit     = pw && (prd != 5'd0);
        pgo     = !m_stall && hit;
        hgo     = (n > 0) && (m_stall || !hit);
        e_ready = (n < DEPTH);
        e_wen   = m_live && (pgo || hgo);
        e_addr  = 5'd0;
        e_data  = 32'd0;
        if (e_wen) begin
            if (pgo) begin
                e_addr = prd;
                e_data = pd;
            end else begin
                e_addr = mq[0].rd;
                e_data = mq[0].data;
            end
        end
        e_p1 = 1'b0;
        e_p2 = 1'b0;
        foreach (mq[i]) begin
            if (q1 != 5'd0 && mq[i].rd == q1) e_p1 = 1'b1;
            if (q2 != 5'd0 && mq[i].rd == q2) e_p2 = 1'b1;
        end
        obs_wen   = rd_wen;
        obs_addr  = rd_addr;
        obs_data  = rd_data;
        obs_ready = lu_ready;
        obs_stall = pipe_stall;
        obs_p1    = rs1_pending;
        obs_p2    = rs2_pending;
        check("rd_wen",      64'(obs_wen),   64'(e_wen));
        check("rd_addr",     64'(obs_addr),  64'(e_addr));
        check("rd_data",     64'(obs_data),  64'(e_data));
        check("lu_ready",    64'(obs_ready), 64'(e_ready));
        check("pipe_stall",  64'(obs_stall), 64'(m_stall));
        check("rs1_pending", 64'(obs_p1),    64'(e_p1));
        check("rs2_pending", 64'(obs_p2),    64'(e_p2));
        if (rst) begin
            if (hgo) void'(mq.pop_front());
            if (lv && e_ready && lrd != 5'd0) begin
                e.rd   = lrd;
                e.data = ld;
                mq.push_back(e);
            end
            if (n == 0) begin
                m_wait = 0;
            end else if (hgo) begin
                m_wait  = 0;
                m_stall = 1'b0;
            end else begin
                m_wait++;
                if (m_wait == LIMIT) m_stall = 1'b1;
            end
            m_live = 1'b1;
        end
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; pipe_wen = 1'b0; pipe_rd = 5'd0; pipe_data = '0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = '0; query_rs1 = 5'd0; query_rs2 = 5'd0;

        // Reset state with an active pipeline request.
        cycle(0, 1, 5'd3, 32'h1, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("rst_wen",   64'(obs_wen),   64'd0);
        check("rst_ready", 64'(obs_ready), 64'd1);
        check("rst_stall", 64'(obs_stall), 64'd0);
        idle(2);

        // Idle drain: one-cycle FIFO latency.
        cycle(1, 0, 5'd0, 32'd0, 1, 5'd5, 32'h11, 5'd0, 5'd0);
        check("idle_first_wen", 64'(obs_wen), 64'd0);
        idle(1);
        check("idle_wen",  64'(obs_wen),  64'd1);
        check("idle_addr", 64'(obs_addr), 64'd5);
        check("idle_data", 64'(obs_data), 64'h11);
        idle(1);
        check("idle_after", 64'(obs_wen), 64'd0);

        // Starvation under continuous pipeline writes to x3.
        cycle(1, 1, 5'd3, 32'h33, 1, 5'd7, 32'hA5, 5'd0, 5'd0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 5'd0, 5'd0);
            check("starve_pipe_addr", 64'(obs_addr),  64'd3);
            check("starve_no_stall",  64'(obs_stall), 64'd0);
        end
        cycle(1, 1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("starve_stall", 64'(obs_stall), 64'd1);
        check("starve_addr",  64'(obs_addr),  64'd7);
        check("starve_data",  64'(obs_data),  64'hA5);
        cycle(1, 1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("starve_clear", 64'(obs_stall), 64'd0);
        idle(2);

        // Full FIFO holds the fifth request, then drains in order.
        for (int k = 0; k < 4; k++)
            cycle(1, 1, 5'd1, 32'h5, 1, 5'(8 + k), 32'(32'h100 + k), 5'd0, 5'd0);
        cycle(1, 1, 5'd1, 32'h5, 1, 5'd12, 32'h200, 5'd0, 5'd0);
        check("full_ready", 64'(obs_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("full_order", 64'(obs_addr), 64'(8 + k));
        end
        idle(1);
        check("full_no_fifth", 64'(obs_wen), 64'd0);

        // x0 handling on both sources.
        cycle(1, 0, 5'd0, 32'd0, 1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
        idle(1);
        check("x0_lu_dropped", 64'(obs_wen), 64'd0);
        cycle(1, 0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 5'd0, 5'd0);
        cycle(1, 1, 5'd0, 32'h77, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("x0_pipe_wen",  64'(obs_wen),  64'd1);
        check("x0_pipe_addr", 64'(obs_addr), 64'd9);
        idle(1);

        // Pending lookup through the cycle the entry is written.
        cycle(1, 1, 5'd2, 32'h2, 1, 5'd12, 32'hC, 5'd0, 5'd0);
        cycle(1, 1, 5'd2, 32'h2, 0, 5'd0, 32'd0, 5'd12, 5'd0);
        check("pend_rs1", 64'(obs_p1), 64'd1);
        check("pend_rs2", 64'(obs_p2), 64'd0);
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd12, 5'd0);
        check("pend_write_addr", 64'(obs_addr), 64'd12);
        check("pend_during",     64'(obs_p1),   64'd1);
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd12, 5'd0);
        check("pend_after", 64'(obs_p1), 64'd0);

        // Reset mid-stream discards queued entries.
        for (int k = 0; k < 3; k++)
            cycle(1, 1, 5'd4, 32'h4, 1, 5'(13 + k), 32'(k), 5'd0, 5'd0);
        cycle(0, 1, 5'd4, 32'h4, 0, 5'd0, 32'd0, 5'd13, 5'd14);
        check("midrst_wen",   64'(obs_wen),   64'd0);
        check("midrst_ready", 64'(obs_ready), 64'd1);
        check("midrst_stall", 64'(obs_stall), 64'd0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("midrst_no_write", 64'(obs_wen), 64'd0);
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  32'($urandom),
                  ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 7)),
                  32'($urandom),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
